// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side output stage.
package async_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned BEAT_CNT_W         = 32;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_TWO   = 2'd2;

endpackage

// File: rtl/fifo_out_skid.sv
// Two-entry head/tail output buffer; occupancy doubles as the FSM state.
module fifo_out_skid
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output occ_t                  occ_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_o
);

  occ_t                  occ_q, occ_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q   <= OCC_EMPTY;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      occ_q   <= occ_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // A push while TWO and a pop while EMPTY are excluded by the read-request gating.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          head_d = push_data_i;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({pop_i, push_i})
          2'b10: occ_d = OCC_EMPTY;
          2'b01: begin
            tail_d = push_data_i;
            occ_d  = OCC_TWO;
          end
          2'b11: head_d = push_data_i;
          default: ;
        endcase
      end
      OCC_TWO: begin
        if (pop_i) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    valid_d = (occ_d != OCC_EMPTY);
  end

  assign occ_o   = occ_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/async_fifo_read_fwft.sv
// FWFT valid/ready adapter on the registered FIFO read port (read_clk domain).
// Optional beat counter: define ASYNC_FIFO_RD_BEAT_COUNT_EN to add p_beat_count.
module async_fifo_read_fwft
  import async_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  read_clk,
  input  logic                  read_rst,
  input  logic                  p_read_empty,
  output logic                  p_read_en,
  input  logic [DATA_WIDTH-1:0] p_read_data,
  output logic                  p_out_valid,
  input  logic                  p_out_ready,
  output logic [DATA_WIDTH-1:0] p_out_data
`ifdef ASYNC_FIFO_RD_BEAT_COUNT_EN
  ,
  output logic [BEAT_CNT_W-1:0] p_beat_count
`endif
);

  logic       inflight_q, inflight_d;
  logic       pop_c;
  logic [2:0] demand_c;
  occ_t       occ;

  assign pop_c    = p_out_valid && p_out_ready;
  // Words held or owed after this cycle's pop; a new read fits only if this is <= 1.
  assign demand_c = 3'(occ) + 3'(inflight_q) - 3'(pop_c);

  always_comb begin
    p_read_en  = !read_rst && !p_read_empty && (demand_c <= 3'd1);
    inflight_d = p_read_en;
  end

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_out_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i      (read_clk),
    .rst_i      (read_rst),
    .push_i     (inflight_q),
    .push_data_i(p_read_data),
    .pop_i      (pop_c),
    .occ_o      (occ),
    .valid_o    (p_out_valid),
    .head_o     (p_out_data)
  );

`ifdef ASYNC_FIFO_RD_BEAT_COUNT_EN
  logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop_c) begin
      beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
    end
  end

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      beat_cnt_q <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign p_beat_count = beat_cnt_q;
`endif

endmodule

// File: tb/tb_async_fifo_read_fwft.sv
// Directed bench for async_fifo_read_fwft with a behavioural registered-read FIFO.
module tb_async_fifo_read_fwft;

  logic        read_clk;
  logic        read_rst;
  logic        p_read_empty;
  logic        p_read_en;
  logic [31:0] p_read_data;
  logic        p_out_valid;
  logic        p_out_ready;
  logic [31:0] p_out_data;
`ifdef ASYNC_FIFO_RD_BEAT_COUNT_EN
  logic [31:0] p_beat_count;
  logic [31:0] s_beat;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  bit          hold_empty;

  logic        s_en, s_empty, s_valid, s_pop;
  logic [31:0] s_data;

  async_fifo_read_fwft #(.DATA_WIDTH(32)) dut (
    .read_clk    (read_clk),
    .read_rst    (read_rst),
    .p_read_empty(p_read_empty),
    .p_read_en   (p_read_en),
    .p_read_data (p_read_data),
    .p_out_valid (p_out_valid),
    .p_out_ready (p_out_ready),
    .p_out_data  (p_out_data)
`ifdef ASYNC_FIFO_RD_BEAT_COUNT_EN
    ,
    .p_beat_count(p_beat_count)
`endif
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  // Sample at the falling edge, then advance the FIFO model just after the rising edge.
  task automatic tick();
    @(negedge read_clk);
    s_en    = p_read_en;
    s_empty = p_read_empty;
    s_valid = p_out_valid;
    s_data  = p_out_data;
    s_pop   = p_out_valid && p_out_ready;
`ifdef ASYNC_FIFO_RD_BEAT_COUNT_EN
    s_beat  = p_beat_count;
`endif
    @(posedge read_clk);
    #1;
    if (s_en && fifo_q.size() > 0) begin
      p_read_data = fifo_q.pop_front();
      exp_q.push_back(p_read_data);
    end
    p_read_empty = (fifo_q.size() == 0) || hold_empty;
  endtask

  task automatic test_reset();
    read_rst     = 1'b1;
    p_out_ready  = 1'b1;
    hold_empty   = 1'b0;
    p_read_data  = '0;
    fifo_q.push_back(32'hDEAD_BEEF);
    p_read_empty = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_en !== 1'b0 || s_valid !== 1'b0 || s_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_c%0d: en=%b valid=%b data=%h required en=0 valid=0 data=0",
                 i, s_en, s_valid, s_data);
      end
`ifdef ASYNC_FIFO_RD_BEAT_COUNT_EN
      checks++;
      if (s_beat !== 32'h0) begin
        errors++;
        $display("FAIL reset_beat: got %0d required 0", s_beat);
      end
`endif
    end
    fifo_q.delete();
    hold_empty   = 1'b1;
    p_read_empty = 1'b1;
    read_rst     = 1'b0;
    tick();
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b en=%b required 0 0", s_valid, s_en);
    end
    exp_q.delete();
  endtask

  task automatic test_single();
    for (int i = 0; i < 10; i++) tick();
    fifo_q.push_back(32'hA5A5_0001);
    hold_empty   = 1'b0;
    p_read_empty = 1'b0;
    tick();
    checks++;
    if (s_en !== 1'b1) begin
      errors++;
      $display("FAIL single_en_c10: got %b required 1", s_en);
    end
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_en !== 1'b0) begin
      errors++;
      $display("FAIL single_c11: valid=%b en=%b required 0 0", s_valid, s_en);
    end
    tick();
    checks++;
    if (s_valid !== 1'b1 || s_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_c12: valid=%b data=%h required 1 a5a50001", s_valid, s_data);
    end
    tick();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c13: valid=%b required 0", s_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_streaming();
    int n;
    for (int i = 0; i < 16; i++) fifo_q.push_back(32'(i));
    p_out_ready  = 1'b1;
    hold_empty   = 1'b0;
    p_read_empty = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_valid && n < 10);
    checks++;
    if (s_valid !== 1'b1 || n != 3) begin
      errors++;
      $display("FAIL stream_first: valid=%b after %0d cycles required 1 after 3", s_valid, n);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (s_valid !== 1'b1 || s_data !== 32'(i)) begin
        errors++;
        $display("FAIL stream_word%0d: valid=%b data=%h required 1 %h", i, s_valid, s_data, 32'(i));
      end
      if (i < 15) tick();
    end
    tick();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b required 0", s_valid);
    end
    exp_q.delete();
    hold_empty = 1'b1;
  endtask

  task automatic test_backpressure();
    int en_cnt;
    int pops;
    int n;
    for (int i = 0; i < 10; i++) fifo_q.push_back(32'd100 + 32'(i));
    p_out_ready  = 1'b0;
    hold_empty   = 1'b0;
    p_read_empty = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (s_en) en_cnt++;
      if (s_valid) begin
        checks++;
        if (s_data !== 32'd100) begin
          errors++;
          $display("FAIL bp_stable_c%0d: data=%0d required 100", i, s_data);
        end
      end
    end
    checks++;
    if (en_cnt != 2 || exp_q.size() != 2 || s_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_fill: en_pulses=%0d reads=%0d valid=%b required 2 2 1",
               en_cnt, exp_q.size(), s_valid);
    end
    p_out_ready = 1'b1;
    pops = 0;
    n = 0;
    while (pops < 10 && n < 40) begin
      tick();
      n++;
      if (s_pop) begin
        checks++;
        if (s_data !== 32'd100 + 32'(pops)) begin
          errors++;
          $display("FAIL bp_order%0d: data=%0d required %0d", pops, s_data, 100 + pops);
        end
        pops++;
      end
    end
    checks++;
    if (pops != 10) begin
      errors++;
      $display("FAIL bp_release: pops=%0d required 10", pops);
    end
    tick();
    checks++;
    if (s_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b required 0", s_valid);
    end
    exp_q.delete();
    hold_empty = 1'b1;
  endtask

  task automatic test_empty_respect();
    int viol;
    int pops;
    int bad;
    logic [31:0] want;
    for (int i = 0; i < 500; i++) fifo_q.push_back(32'h1000 + 32'(i));
    viol = 0;
    pops = 0;
    bad  = 0;
    for (int i = 0; i < 510; i++) begin
      if (i < 500) begin
        hold_empty  = ($urandom_range(0, 1) == 1);
        p_out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        hold_empty  = 1'b1;
        p_out_ready = 1'b1;
      end
      tick();
      if (s_en && s_empty) viol++;
      if (s_pop) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
        if (s_data !== want) begin
          bad++;
          if (bad < 5) $display("FAIL er_order: data=%h required %h", s_data, want);
        end
        pops++;
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL er_read_while_empty: count=%0d required 0", viol);
    end
    checks++;
    if (bad != 0 || pops < 50 || exp_q.size() != 0 || s_valid !== 1'b0) begin
      errors++;
      $display("FAIL er_sequence: bad=%0d pops=%0d left=%0d valid=%b required 0 >=50 0 0",
               bad, pops, exp_q.size(), s_valid);
    end
    fifo_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midstream();
    int pops;
    int n;
    hold_empty   = 1'b1;
    p_read_empty = 1'b1;
    read_rst     = 1'b1;
    tick();
    read_rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 20; i++) fifo_q.push_back(32'h2000 + 32'(i));
    p_out_ready  = 1'b1;
    hold_empty   = 1'b0;
    p_read_empty = 1'b0;
    pops = 0;
    n = 0;
    while (pops < 7 && n < 50) begin
      tick();
      n++;
      if (s_pop) begin
        checks++;
        if (s_data !== 32'h2000 + 32'(pops)) begin
          errors++;
          $display("FAIL mid_order%0d: data=%h required %h", pops, s_data, 32'h2000 + 32'(pops));
        end
        pops++;
      end
    end
    p_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (s_valid !== 1'b1 || s_data !== 32'h2007) begin
      errors++;
      $display("FAIL mid_prereset: valid=%b data=%h required 1 00002007", s_valid, s_data);
    end
`ifdef ASYNC_FIFO_RD_BEAT_COUNT_EN
    checks++;
    if (s_beat !== 32'd7) begin
      errors++;
      $display("FAIL mid_beat_before: got %0d required 7", s_beat);
    end
`endif
    read_rst   = 1'b1;
    hold_empty = 1'b1;
    tick();
    checks++;
    if (s_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_en: got %b required 0", s_en);
    end
    read_rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    p_read_empty = 1'b1;
    tick();
    checks++;
    if (s_valid !== 1'b0 || s_data !== 32'h0) begin
      errors++;
      $display("FAIL mid_after: valid=%b data=%h required 0 0", s_valid, s_data);
    end
`ifdef ASYNC_FIFO_RD_BEAT_COUNT_EN
    checks++;
    if (s_beat !== 32'd0) begin
      errors++;
      $display("FAIL mid_beat_after: got %0d required 0", s_beat);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_empty_respect();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
